// File: rtl/spi_pkg.sv
// Shared state encoding and mode-bit layout for the frame-based SPI slave.
// Latency: none (types and constants only).
// Backpressure: none.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } spi_state_e;

    // Bit positions inside the latched {cpol, cpha} mode register
    localparam int unsigned MODE_CPHA_BIT = 0;
    localparam int unsigned MODE_CPOL_BIT = 1;

    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus rise/fall detection.
// Latency: STAGES cycles to dout; rise/fall are combinational on dout vs. its previous value.
// Backpressure: none, free-running.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned STAGES  = SYNC_STAGES_DEF,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the pin into the chain and keep a one-cycle-old copy of the output
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // Chain and delayed copy reset to the pin's idle level so no false edge follows reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_frame.sv
// Oversampled SPI slave, multi-word frames under one cs, run-time CPOL/CPHA, sys_clk only.
// Latency: pin edge to action SYNC_STAGES+1 cycles; last sampled bit to rx_valid 1 cycle after sync.
// Backpressure: none toward the master; rx_valid held until rx_ready (overrun overwrites), missing tx_valid sends zeros.
module spi_slave_frame
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic [7:0]        word_cnt
);

    localparam int unsigned    BCW      = $clog2(DATA_W);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(cs),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    // mosi only needs the same delay as sclk so it is sampled at the matching edge
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_d;
    logic                   mosi_s;

    spi_state_e        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              first_q, first_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_end_q, frame_end_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic [7:0]        word_cnt_q, word_cnt_d;

    logic              cpol_l, cpha_l;
    logic              sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic [DATA_W-1:0] rx_word, load_word;
    logic              load_req;

    function automatic logic tx_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Leading/trailing are judged against the cpol captured at frame start, not the live pin
    assign cpol_l      = mode_q[MODE_CPOL_BIT];
    assign cpha_l      = mode_q[MODE_CPHA_BIT];
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge & (sclk_s != cpol_l);
    assign trail_edge  = sclk_edge & (sclk_s == cpol_l);
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign shift_edge  = cpha_l ? lead_edge : trail_edge;
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign rx_word     = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh_q[DATA_W-1:1]};
    assign load_word   = tx_valid ? tx_data : '0;

    // mosi synchroniser chain
    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    // Frame FSM, shift registers, handshakes and status pulses
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        bit_cnt_d     = bit_cnt_q;
        first_d       = first_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~rx_ready;
        word_cnt_d    = word_cnt_q;
        tx_ready_d    = 1'b0;
        tx_underrun_d = 1'b0;
        rx_overrun_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        load_req      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d                = ST_LOAD;
                    mode_d[MODE_CPOL_BIT]  = cpol;
                    mode_d[MODE_CPHA_BIT]  = cpha;
                    frame_start_d          = 1'b1;
                    word_cnt_d             = '0;
                    bit_cnt_d              = '0;
                    rx_sh_d                = '0;
                    miso_oe_d              = 1'b1;
                end
            end
            ST_LOAD: begin
                load_req = 1'b1;
                state_d  = ST_ACTIVE;
                // cpha=0 masters sample before any shift edge, so bit 0 must be out now
                first_d  = cpha_l;
                if (!cpha_l) begin
                    miso_d = tx_bit(load_word);
                end
            end
            ST_ACTIVE: begin
                // edges seen while cs is already deasserted belong to no frame
                if (!cs_s && shift_edge) begin
                    if (first_q) begin
                        miso_d  = tx_bit(tx_sh_q);
                        first_d = 1'b0;
                    end else begin
                        tx_sh_d = tx_adv(tx_sh_q);
                        miso_d  = tx_bit(tx_adv(tx_sh_q));
                    end
                end
                if (!cs_s && sample_edge) begin
                    rx_sh_d = rx_word;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d    = '0;
                        rx_data_d    = rx_word;
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_valid_q & ~rx_ready;
                        word_cnt_d   = (word_cnt_q == 8'hFF) ? 8'hFF : word_cnt_q + 8'd1;
                        load_req     = 1'b1;
                        // new word's first bit waits for the next shift edge in both modes
                        first_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_req) begin
            tx_sh_d       = load_word;
            tx_ready_d    = tx_valid;
            tx_underrun_d = ~tx_valid;
        end

        // cs release ends the frame from any state; a word loaded this cycle is still consumed
        if (cs_rise) begin
            state_d     = ST_IDLE;
            frame_end_d = 1'b1;
            miso_oe_d   = 1'b0;
            miso_d      = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            mosi_sync_q   <= '0;
            state_q       <= ST_IDLE;
            mode_q        <= '0;
            tx_sh_q       <= '0;
            rx_sh_q       <= '0;
            bit_cnt_q     <= '0;
            first_q       <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            tx_ready_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            mode_q        <= mode_d;
            tx_sh_q       <= tx_sh_d;
            rx_sh_q       <= rx_sh_d;
            bit_cnt_q     <= bit_cnt_d;
            first_q       <= first_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            tx_ready_q    <= tx_ready_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: bit-level SPI master model driving an 8-bit MSB-first and a 16-bit LSB-first instance.
// Expected data are the words the master sent / the TX words offered; pulse counts follow the frame rules.
// Runs a fixed number of cycles; no open-ended waits.
module tb_spi_slave_frame;

    localparam int H = 8;   // sclk half period in sys_clk cycles

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    logic cpol, cpha, sclk, mosi, cs8, cs16;

    logic       miso8, oe8, txv8, trdy8, rxv8, rxr8, fs8, fe8, ovr8, und8;
    logic [7:0] txd8, rxd8, wc8;

    logic        miso16, oe16, txv16, trdy16, rxv16, rxr16, fs16, fe16, ovr16, und16;
    logic [15:0] txd16, rxd16;
    logic [7:0]  wc16;

    spi_slave_frame #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut8 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cpol(cpol), .cpha(cpha),
        .cs(cs8), .sclk(sclk), .mosi(mosi), .miso(miso8), .miso_oe(oe8),
        .tx_data(txd8), .tx_valid(txv8), .tx_ready(trdy8),
        .rx_data(rxd8), .rx_valid(rxv8), .rx_ready(rxr8),
        .frame_start(fs8), .frame_end(fe8), .rx_overrun(ovr8),
        .tx_underrun(und8), .word_cnt(wc8)
    );

    spi_slave_frame #(.DATA_W(16), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut16 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cpol(cpol), .cpha(cpha),
        .cs(cs16), .sclk(sclk), .mosi(mosi), .miso(miso16), .miso_oe(oe16),
        .tx_data(txd16), .tx_valid(txv16), .tx_ready(trdy16),
        .rx_data(rxd16), .rx_valid(rxv16), .rx_ready(rxr16),
        .frame_start(fs16), .frame_end(fe16), .rx_overrun(ovr16),
        .tx_underrun(und16), .word_cnt(wc16)
    );

    int checks = 0;
    int errors = 0;
    int sel    = 0;     // 0 = master talks to u_dut8, 1 = u_dut16
    int cyc    = 0;
    int last_samp = 0;
    int rxv_cyc8  = 0;
    logic rxv_prev8 = 1'b0;

    int fs_n8 = 0, fe_n8 = 0, trdy_n8 = 0, und_n8 = 0, ovr_n8 = 0, acc_n8 = 0;
    int b_fs, b_fe, b_trdy, b_und, b_ovr, b_acc;
    logic [7:0] txq8[$];
    logic [7:0] rxq8[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse counters, RX consumer capture and TX word supplier for u_dut8
    initial begin
        forever begin
            @(negedge sys_clk);
            if (fs8)  fs_n8++;
            if (fe8)  fe_n8++;
            if (und8) und_n8++;
            if (ovr8) ovr_n8++;
            if (rxv8 && rxr8) begin
                acc_n8++;
                rxq8.push_back(rxd8);
            end
            if (rxv8 && !rxv_prev8) rxv_cyc8 = cyc;
            rxv_prev8 = rxv8;
            if (trdy8) begin
                trdy_n8++;
                if (txq8.size() > 1) void'(txq8.pop_front());
            end
            txd8 = (txq8.size() > 0) ? txq8[0] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_fs = fs_n8; b_fe = fe_n8; b_trdy = trdy_n8;
        b_und = und_n8; b_ovr = ovr_n8; b_acc = acc_n8;
    endtask

    task automatic frame_begin(input bit c_pol, input bit c_pha);
        cpol = c_pol;
        cpha = c_pha;
        sclk = c_pol;
        repeat (10) @(negedge sys_clk);
        if (sel != 0) cs16 = 1'b0; else cs8 = 1'b0;
        repeat (H) @(negedge sys_clk);
    endtask

    task automatic frame_stop();
        if (sel != 0) cs16 = 1'b1; else cs8 = 1'b1;
        repeat (10) @(negedge sys_clk);
    endtask

    // Master side of one word: drives mosi, toggles sclk, samples miso on the sample edge
    task automatic xfer(input int nb, input bit msb, input logic [31:0] wo, output logic [31:0] wi);
        int b;
        wi = '0;
        for (int i = 0; i < nb; i++) begin
            b = msb ? (nb - 1 - i) : i;
            if (!cpha) begin
                mosi = wo[b];
                repeat (H) @(negedge sys_clk);
                sclk = ~cpol;
                wi[b] = (sel != 0) ? miso16 : miso8;
                last_samp = cyc;
                repeat (H) @(negedge sys_clk);
                sclk = cpol;
            end else begin
                repeat (H) @(negedge sys_clk);
                sclk = ~cpol;
                mosi = wo[b];
                repeat (H) @(negedge sys_clk);
                sclk = cpol;
                wi[b] = (sel != 0) ? miso16 : miso8;
                last_samp = cyc;
            end
        end
        repeat (H) @(negedge sys_clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  win[3];
        logic [7:0]  wtx[3];
        int          n;
        bit          rp, rh;

        sys_rst_n = 1'b0;
        cs8 = 1'b1; cs16 = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
        txv8 = 1'b1; rxr8 = 1'b1;
        txv16 = 1'b1; rxr16 = 1'b0; txd16 = 16'h1234;
        txq8.push_back(8'h3C);
        repeat (3) @(negedge sys_clk);

        check("rst_rx_valid", rxv8, 0);
        check("rst_miso_oe", oe8, 0);
        check("rst_word_cnt", wc8, 0);
        check("rst_rx_data", rxd8, 0);
        check("rst_miso", miso8, 0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Mode 0, single word
        snap(); rxq8.delete();
        frame_begin(1'b0, 1'b0);
        xfer(8, 1'b1, 32'hA5, rd);
        check("m0_rx_latency", rxv_cyc8 - last_samp, 3);
        frame_stop();
        check("m0_rx_data", rxd8, 8'hA5);
        check("m0_rx_accepts", acc_n8 - b_acc, 1);
        check("m0_master_read", rd, 8'h3C);
        check("m0_word_cnt", wc8, 1);
        check("m0_frame_start", fs_n8 - b_fs, 1);
        check("m0_frame_end", fe_n8 - b_fe, 1);
        check("m0_miso_oe_off", oe8, 0);

        // Mode 3, three words with a fresh TX word per load
        snap(); rxq8.delete(); txq8.delete();
        txq8.push_back(8'hC1); txq8.push_back(8'hC2); txq8.push_back(8'hC3);
        repeat (2) @(negedge sys_clk);
        frame_begin(1'b1, 1'b1);
        xfer(8, 1'b1, 32'h11, rd); check("m3_read0", rd, 8'hC1);
        xfer(8, 1'b1, 32'h22, rd); check("m3_read1", rd, 8'hC2);
        xfer(8, 1'b1, 32'h33, rd); check("m3_read2", rd, 8'hC3);
        frame_stop();
        check("m3_rx_cnt", rxq8.size(), 3);
        if (rxq8.size() == 3) begin
            check("m3_rx0", rxq8[0], 8'h11);
            check("m3_rx1", rxq8[1], 8'h22);
            check("m3_rx2", rxq8[2], 8'h33);
        end
        check("m3_overrun", ovr_n8 - b_ovr, 0);
        check("m3_tx_ready", trdy_n8 - b_trdy, 4);
        check("m3_word_cnt", wc8, 3);

        // TX underrun for a whole two-word frame
        snap(); txv8 = 1'b0;
        frame_begin(1'b0, 1'b0);
        xfer(8, 1'b1, 32'h0F, rd); check("und_read0", rd, 0);
        xfer(8, 1'b1, 32'hF0, rd); check("und_read1", rd, 0);
        frame_stop();
        check("und_pulses", und_n8 - b_und, 3);
        check("und_tx_ready", trdy_n8 - b_trdy, 0);
        txv8 = 1'b1;

        // RX overrun with rx_ready held low, mode 2
        snap(); rxr8 = 1'b0;
        frame_begin(1'b1, 1'b0);
        xfer(8, 1'b1, 32'h5A, rd);
        xfer(8, 1'b1, 32'h6B, rd);
        frame_stop();
        check("ovr_pulses", ovr_n8 - b_ovr, 1);
        check("ovr_rx_data", rxd8, 8'h6B);
        check("ovr_rx_valid_held", rxv8, 1);
        rxr8 = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("ovr_rx_valid_cleared", rxv8, 0);

        // Aborted frame after 5 sclk cycles, then a clean frame
        snap(); rxr8 = 1'b0;
        frame_begin(1'b0, 1'b0);
        xfer(5, 1'b1, 32'h1F, rd);
        frame_stop();
        check("abort_rx_valid", rxv8, 0);
        check("abort_frame_end", fe_n8 - b_fe, 1);
        check("abort_miso_oe", oe8, 0);
        check("abort_miso", miso8, 0);
        check("abort_word_cnt", wc8, 0);
        snap(); rxr8 = 1'b1;
        frame_begin(1'b0, 1'b0);
        xfer(8, 1'b1, 32'h96, rd);
        frame_stop();
        check("after_abort_rx", rxd8, 8'h96);
        check("after_abort_accepts", acc_n8 - b_acc, 1);

        // cs glitch with no sclk activity
        snap();
        cs8 = 1'b0;
        repeat (4) @(negedge sys_clk);
        cs8 = 1'b1;
        repeat (10) @(negedge sys_clk);
        check("glitch_start", fs_n8 - b_fs, 1);
        check("glitch_end", fe_n8 - b_fe, 1);
        check("glitch_load", (trdy_n8 - b_trdy) + (und_n8 - b_und), 1);
        check("glitch_no_rx", acc_n8 - b_acc, 0);

        // Random frames: random mode, 1..3 words, random RX and TX data
        for (int f = 0; f < 6; f++) begin
            rp = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(1, 3));
            snap(); rxq8.delete(); txq8.delete();
            for (int i = 0; i < 3; i++) begin
                win[i] = 8'($urandom);
                wtx[i] = 8'($urandom);
                if (i < n) txq8.push_back(wtx[i]);
            end
            repeat (2) @(negedge sys_clk);
            frame_begin(rp, rh);
            for (int i = 0; i < n; i++) begin
                xfer(8, 1'b1, {24'h0, win[i]}, rd);
                check("rnd_master_read", rd, {24'h0, wtx[i]});
            end
            frame_stop();
            check("rnd_rx_cnt", rxq8.size(), n);
            for (int i = 0; i < n && i < rxq8.size(); i++) check("rnd_rx_data", rxq8[i], win[i]);
            check("rnd_word_cnt", wc8, n);
            check("rnd_tx_ready", trdy_n8 - b_trdy, n + 1);
        end

        // 16-bit LSB-first instance, mode 1
        sel = 1;
        frame_begin(1'b0, 1'b1);
        xfer(16, 1'b0, 32'hBEEF, rd);
        frame_stop();
        check("w16_rx_data", rxd16, 16'hBEEF);
        check("w16_rx_valid", rxv16, 1);
        check("w16_master_read", rd, 16'h1234);
        check("w16_word_cnt", wc16, 1);

        // Reset in the middle of a word
        frame_begin(1'b0, 1'b1);
        xfer(7, 1'b0, 32'h00A5, rd);
        check("w16_oe_midword", oe16, 1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("mrst_miso", miso16, 0);
        check("mrst_miso_oe", oe16, 0);
        check("mrst_rx_data", rxd16, 0);
        check("mrst_rx_valid", rxv16, 0);
        check("mrst_word_cnt", wc16, 0);
        check("mrst_pulses", {fs16, fe16, trdy16, ovr16, und16}, 0);
        check("mrst_dut8_rx_data", rxd8, 0);
        cs16 = 1'b1;
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_frame.md
Name: spi_slave_frame

Overview:
Oversampled SPI slave for multi-word frames, clocked entirely by sys_clk. It is the parametrised successor of the single-byte SPI slave, with configurable word width and bit order, run-time CPOL/CPHA, and multi-word frames under one chip-select. RX and TX use valid/ready handshakes, with overrun and underrun flags. It sits between the MCU SPI pins and the FPGA register/FIFO fabric.

Parameters:
DATA_W, 8, word width in bits (4..32)
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
SYNC_STAGES, 2, synchroniser depth on cs/sclk/mosi (>= 2)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  synchronous active-low reset
cpol  in  1  clock idle level; latched at frame start
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start
cs  in  1  chip select, active low, asynchronous
sclk  in  1  SPI clock, asynchronous
mosi  in  1  master-out data, asynchronous
miso  out  1  slave-out data, registered
miso_oe  out  1  high while frame active; pad tristate is done at top level
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  1-cycle pulse, tx_data consumed
rx_data  out  DATA_W  last received word
rx_valid  out  1  held high until rx_ready
rx_ready  in  1  consumer accepts rx_data
frame_start  out  1  1-cycle pulse on synced cs fall
frame_end  out  1  1-cycle pulse on synced cs rise
rx_overrun  out  1  1-cycle pulse, word completed while rx_valid still high
tx_underrun  out  1  1-cycle pulse, word load with tx_valid low
word_cnt  out  8  words completed in current frame, saturates at 255

Behaviour:
- Reset (sys_rst_n = 0 at a sys_clk edge):
  - State returns to IDLE.
  - All outputs go to 0: miso, miso_oe, tx_ready, rx_data, rx_valid, all pulse outputs, word_cnt.
  - Synchroniser stages are set to idle values: cs = 1, sclk = 0.
  - Reset mid-frame discards all partial data.
- Input path:
  - cs, sclk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synced cs and sclk against a one-cycle-delayed copy.
- Edge definitions:
  - Leading edge: synced sclk leaves the latched cpol level. Trailing edge: it returns to that level.
  - sample_edge = cpha ? trailing : leading.
  - shift_edge = the other edge.
- Timing requirement: sclk high and low times must each be >= SYNC_STAGES+3 sys_clk periods.
- State machine: IDLE, LOAD, ACTIVE.
  - IDLE -> LOAD on synced cs fall:
    - Latch cpol/cpha; pulse frame_start; clear word_cnt and the bit counter; set miso_oe = 1.
  - LOAD (1 cycle) -> ACTIVE, performing a word load:
    - If tx_valid = 1: shift register <= tx_data and tx_ready pulses.
    - Otherwise: shift register <= 0 and tx_underrun pulses.
    - If cpha = 0, miso is driven with the first bit in the same cycle.
  - ACTIVE, on shift_edge:
    - cpha = 1 and first edge of a word: drive the first bit.
    - Otherwise: advance the shift register and drive the next bit.
    - Bit order follows MSB_FIRST.
  - ACTIVE, on sample_edge:
    - Shift in the synced mosi and increment the bit counter.
    - On the DATA_W-th bit:
      - rx_data <= assembled word; rx_valid <= 1.
      - If rx_valid was still 1 and not acknowledged this cycle, pulse rx_overrun; new data overwrites.
      - word_cnt increments, saturating at 255.
      - Bit counter wraps to 0.
      - A word load (same rule as LOAD) occurs; its first bit appears on the next shift_edge, for both cpha values.
  - Any state -> IDLE on synced cs rise:
    - Pulse frame_end; set miso_oe = 0 and miso = 0.
    - Partial words are discarded with no rx_valid; a loaded TX word is consumed and not replayed.
- rx handshake: rx_valid clears on a cycle where rx_ready = 1, unless a new word completes in that same cycle, in which case rx_valid stays 1 with the new data and no overrun.
- Glitches: cs fall then rise with no sclk edges produces frame_start, one tx_ready or tx_underrun, and frame_end, with no rx_valid.
- Latency: synced-mosi sample to rx_valid high is 1 sys_clk; pin edge to action is SYNC_STAGES+1 sys_clk.

Decomposition:
- Package spi_pkg: state encoding constants (IDLE, LOAD, ACTIVE), mode bit positions, and the SYNC_STAGES default.
- Sub-module spi_sync_edge: parametrised synchroniser plus rise/fall detector with a reset value parameter. Instantiated for cs (reset 1) and sclk (reset 0); mosi uses the synchroniser output only.

Test Plan:
- Mode 0 (cpol = 0, cpha = 0), DATA_W = 8, tx_data = 0x3C held valid, master sends 0xA5 -> rx_data = 0xA5 with one rx_valid; master reads 0x3C; word_cnt = 1; frame_start and frame_end each pulse once.
- Mode 3, three words 0x11/0x22/0x33 in, TX supplies 0xC1/0xC2/0xC3 -> master reads C1, C2, C3; rx_ready pulsed each word; no overrun; tx_ready pulses 3 times (plus one for the final post-word load).
- tx_valid held 0 for the whole frame -> master reads 0x00; tx_underrun pulses at the frame-start load and after each completed word.
- rx_ready held 0, two words 0x5A then 0x6B -> rx_overrun pulses once at the second word; rx_data = 0x6B.
- cs raised after 5 sclk cycles -> no rx_valid, frame_end pulses, miso_oe = 0, word_cnt = 0; the next full frame receives correctly.
- DATA_W = 16, MSB_FIRST = 0, mode 1, master sends 0xBEEF LSB-first -> rx_data = 0xBEEF. Assert sys_rst_n = 0 mid-word -> all outputs return to 0 on the next edge.
